// File: rtl/gate_chk_pkg.sv
// Shared encodings for the two-input gate sweep checker: gate selects, FSM states, vector count.
package gate_chk_pkg;

  localparam int unsigned NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_XOR  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_BUF  = 3'd6,
    GATE_NOT  = 3'd7
  } gate_sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and whoever starts it and hosts the gate.
interface gate_sweep_checker_if #(
  parameter int unsigned ERR_W = 3
);
  logic             start;
  logic [2:0]       gate_sel;
  logic             gate_out;
  logic             in1;
  logic             in2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       vec_idx;

  modport master (
    output start, gate_sel, gate_out,
    input  in1, in2, busy, done, pass, err_count, vec_idx
  );

  modport slave (
    input  start, gate_sel, gate_out,
    output in1, in2, busy, done, pass, err_count, vec_idx
  );
endinterface

// File: rtl/gate_ref_model.sv
// Reference truth function for the eight supported two-input gate primitives.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       in1,
  input  logic       in2,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (gate_sel_e'(sel))
      GATE_AND:  expected = in1 & in2;
      GATE_OR:   expected = in1 | in2;
      GATE_XOR:  expected = in1 ^ in2;
      GATE_NAND: expected = ~(in1 & in2);
      GATE_NOR:  expected = ~(in1 | in2);
      GATE_XNOR: expected = ~(in1 ^ in2);
      GATE_BUF:  expected = in1;
      GATE_NOT:  expected = ~in1;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all four input vectors through a gate, settles, samples and counts mismatches.
// Optional GATE_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_sweep_checker_if.slave  bus
);

  localparam int unsigned      CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [1:0]       LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_bit;
  logic             mismatch;

  gate_ref_model u_ref (
    .sel      (sel_q),
    .in1      (vec_q[1]),
    .in2      (vec_q[0]),
    .expected (exp_bit)
  );

  assign mismatch = (bus.gate_out != exp_bit);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sel_d   = bus.gate_sel;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = SETTLE_LOAD;
        state_d = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSample: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (mismatch || (vec_q == LAST_VEC)) begin
`else
        if (vec_q == LAST_VEC) begin
`endif
          // Evaluate pass from the updated count so it is valid while done is high.
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in1       = vec_q[1];
  assign bus.in2       = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

endmodule
